// File: rtl/udp_link_ctrl.sv
// ARP/link supervisor: resolves NUM_CH peers through mac_top's ARP engine, keeps them alive and gates write_sel.
// Define LINK_CTRL_STATS_EN to add saturating arp_req_cnt / arp_fail_cnt outputs.
module udp_link_ctrl #(
  parameter int NUM_CH        = 2,
  parameter int CH_W          = 1,
  parameter int STARTUP_CYC   = 125_000_000,
  parameter int ARP_WAIT_CYC  = 125_000_000,
  parameter int KEEPALIVE_CYC = 125_000_000,
  parameter int MAX_RETRY     = 4
) (
  input  logic              gmii_tx_clk,
  input  logic              rst,
  output logic              arp_request_req,
  output logic [CH_W-1:0]   arp_req_ch,
  input  logic              mac_send_end,
  input  logic              arp_found,
  input  logic [CH_W-1:0]   arp_found_ch,
  input  logic              mac_not_exist,
  input  logic              almost_full,
  input  logic              udp_rec_data_valid,
  input  logic [CH_W-1:0]   udp_rec_ch,
  output logic [NUM_CH-1:0] ch_resolved,
  output logic [NUM_CH-1:0] ch_failed,
  output logic [NUM_CH-1:0] write_sel,
  output logic [5:0]        link_state
`ifdef LINK_CTRL_STATS_EN
  ,
  output logic [15:0]       arp_req_cnt,
  output logic [15:0]       arp_fail_cnt
`endif
);

  localparam int CNT_W = 32;
  localparam int RTY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [CNT_W-1:0] STARTUP_LAST   = CNT_W'(STARTUP_CYC - 1);
  localparam logic [CNT_W-1:0] ARP_WAIT_LAST  = CNT_W'(ARP_WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] KEEPALIVE_LAST = CNT_W'(KEEPALIVE_CYC - 1);
  localparam logic [RTY_W-1:0] RETRY_LAST     = RTY_W'(MAX_RETRY - 1);
  localparam logic [CH_W-1:0]  LAST_CH        = CH_W'(NUM_CH - 1);

  typedef enum logic [5:0] {
    S_IDLE      = 6'b000001,
    S_ARP_REQ   = 6'b000010,
    S_ARP_SEND  = 6'b000100,
    S_ARP_WAIT  = 6'b001000,
    S_WAIT_REC  = 6'b010000,
    S_CHECK_ARP = 6'b100000
  } state_e;

  state_e             state_q, state_d;
  logic [CH_W-1:0]    cur_ch_q, cur_ch_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RTY_W-1:0]   retry_cnt_q, retry_cnt_d;
  logic [NUM_CH-1:0]  resolved_q, resolved_d;
  logic [NUM_CH-1:0]  failed_q, failed_d;
  logic [NUM_CH-1:0]  write_sel_q, write_sel_d;
  logic               almost_full_d1_q, almost_full_d1_d;
  logic [NUM_CH-1:0]  cur_mask;
  logic               limit_hit;
  logic               advance;
  logic               fail_set;

  always_comb begin
    state_d          = state_q;
    cur_ch_d         = cur_ch_q;
    retry_cnt_d      = retry_cnt_q;
    resolved_d       = resolved_q;
    failed_d         = failed_q;
    write_sel_d      = '0;
    almost_full_d1_d = almost_full;
    limit_hit        = 1'b0;
    advance          = 1'b0;
    fail_set         = 1'b0;
    cur_mask         = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_mask[i] = (cur_ch_q == CH_W'(i));
    end

    case (state_q)
      S_IDLE:     limit_hit = (wait_cnt_q == STARTUP_LAST);
      S_ARP_WAIT: limit_hit = (wait_cnt_q == ARP_WAIT_LAST);
      S_WAIT_REC: limit_hit = (wait_cnt_q == KEEPALIVE_LAST);
      default:    limit_hit = 1'b0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (limit_hit) begin
          state_d     = S_ARP_REQ;
          cur_ch_d    = '0;
          retry_cnt_d = '0;
          resolved_d  = '0;
          failed_d    = '0;
        end
      end
      S_ARP_REQ: state_d = S_ARP_SEND;
      S_ARP_SEND: begin
        if (mac_send_end) state_d = S_ARP_WAIT;
      end
      S_ARP_WAIT: begin
        // A matching reply on the timeout cycle still counts as resolved.
        if (arp_found && (arp_found_ch == cur_ch_q)) begin
          resolved_d = resolved_q | cur_mask;
          advance    = 1'b1;
        end else if (limit_hit) begin
          if (retry_cnt_q == RETRY_LAST) begin
            failed_d = failed_q | cur_mask;
            fail_set = 1'b1;
            advance  = 1'b1;
          end else begin
            retry_cnt_d = retry_cnt_q + 1'b1;
            state_d     = S_ARP_REQ;
          end
        end
        if (advance) begin
          retry_cnt_d = '0;
          if (cur_ch_q != LAST_CH) begin
            cur_ch_d = cur_ch_q + 1'b1;
            state_d  = S_ARP_REQ;
          end else begin
            state_d = (|resolved_d) ? S_WAIT_REC : S_IDLE;
          end
        end
      end
      S_WAIT_REC: begin
        for (int i = 0; i < NUM_CH; i++) begin
          write_sel_d[i] = udp_rec_data_valid && (udp_rec_ch == CH_W'(i)) && resolved_q[i];
        end
        if (limit_hit) state_d = S_CHECK_ARP;
      end
      S_CHECK_ARP: begin
        write_sel_d = write_sel_q;
        if (mac_not_exist) begin
          resolved_d  = '0;
          cur_ch_d    = '0;
          retry_cnt_d = '0;
          state_d     = S_ARP_REQ;
        end else if (!almost_full_d1_q) begin
          state_d = S_WAIT_REC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The dwell counter restarts on every state change.
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if ((state_q == S_IDLE) || (state_q == S_ARP_WAIT) || (state_q == S_WAIT_REC)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end else begin
      wait_cnt_d = '0;
    end
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      cur_ch_q         <= '0;
      wait_cnt_q       <= '0;
      retry_cnt_q      <= '0;
      resolved_q       <= '0;
      failed_q         <= '0;
      write_sel_q      <= '0;
      almost_full_d1_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cur_ch_q         <= cur_ch_d;
      wait_cnt_q       <= wait_cnt_d;
      retry_cnt_q      <= retry_cnt_d;
      resolved_q       <= resolved_d;
      failed_q         <= failed_d;
      write_sel_q      <= write_sel_d;
      almost_full_d1_q <= almost_full_d1_d;
    end
  end

  assign arp_request_req = (state_q == S_ARP_REQ);
  assign arp_req_ch      = cur_ch_q;
  assign ch_resolved     = resolved_q;
  assign ch_failed       = failed_q;
  assign write_sel       = write_sel_q;
  assign link_state      = state_q;

`ifdef LINK_CTRL_STATS_EN
  logic [15:0] req_cnt_q, req_cnt_d;
  logic [15:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    req_cnt_d  = req_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (arp_request_req && (req_cnt_q != 16'hFFFF)) req_cnt_d = req_cnt_q + 16'd1;
    if (fail_set && (fail_cnt_q != 16'hFFFF)) fail_cnt_d = fail_cnt_q + 16'd1;
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (rst) begin
      req_cnt_q  <= '0;
      fail_cnt_q <= '0;
    end else begin
      req_cnt_q  <= req_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign arp_req_cnt  = req_cnt_q;
  assign arp_fail_cnt = fail_cnt_q;
`endif

endmodule
